// File: rtl/bank_buf_pkg.sv
// bank_buf_pkg: width helpers and reset bank indices shared by bank_buf and bank_buf_ram.
package bank_buf_pkg;

  localparam int RST_RD_BANK = 0;
  localparam int RST_WR_BANK = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Vectors need at least one bit even when the count is 1.
  function automatic int bank_w(input int nbanks);
    return (clog2(nbanks) < 1) ? 1 : clog2(nbanks);
  endfunction

  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/bank_buf_ram.sv
// bank_buf_ram: simple dual-port bank store, NBANKS*DEPTH words addressed {bank, word},
// one write port and one registered read port.
module bank_buf_ram
  import bank_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NBANKS     = 3
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_we,
  input  logic [bank_w(NBANKS)+addr_w(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]                  i_wdata,
  input  logic [bank_w(NBANKS)+addr_w(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]                  o_rdata
);
  localparam int AW = addr_w(DEPTH);
  localparam int BW = bank_w(NBANKS);

  logic [DATA_WIDTH-1:0] r_mem [NBANKS][DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [BW-1:0]         w_wbank;
  logic [BW-1:0]         w_rbank;
  logic [AW-1:0]         w_wword;
  logic [AW-1:0]         w_rword;

  assign {w_wbank, w_wword} = i_waddr;
  assign {w_rbank, w_rword} = i_raddr;
  assign o_rdata = r_rdata;

  // Storage is never reset; only the read register is.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[w_wbank][w_wword] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rdata <= '0;
    else          r_rdata <= r_mem[w_rbank][w_rword];
  end

endmodule

// File: rtl/bank_buf.sv
// bank_buf: ring of NBANKS banks; the writer fills one bank while the reader scans another.
// Define BANK_BUF_LATEST_EN to make iswap jump to the newest committed bank instead of FIFO order.
module bank_buf
  import bank_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NBANKS     = 3
) (
  input  logic                      iclk,
  input  logic                      irst_n,
  input  logic [DATA_WIDTH-1:0]     idata,
  input  logic                      iwr,
  input  logic                      icommit,
  input  logic                      iswap,
  input  logic [addr_w(DEPTH)-1:0]  iraddr,
  output logic [DATA_WIDTH-1:0]     odata,
  output logic [bank_w(NBANKS)-1:0] owr_bank,
  output logic [bank_w(NBANKS)-1:0] ord_bank,
  output logic [bank_w(NBANKS)-1:0] opending,
  output logic                      odrop,
  output logic                      ofull
);
  localparam int AW = addr_w(DEPTH);
  localparam int BW = bank_w(NBANKS);
  localparam logic [BW-1:0] LAST_BANK  = BW'(NBANKS - 1);
  localparam logic [BW-1:0] PEND_LIMIT = BW'(NBANKS - 2);
  localparam logic [AW-1:0] LAST_WORD  = AW'(DEPTH - 1);

  logic [BW-1:0] r_wr_bank;
  logic [BW-1:0] r_rd_bank;
  logic [BW-1:0] r_pending;
  logic [AW-1:0] r_waddr;
  logic          r_full;
  logic          r_drop;
  logic          w_wen;
  logic          w_accept;
  logic          w_take;
  logic [BW-1:0] w_wr_bank_nxt;
  logic [BW-1:0] w_rd_bank_nxt;
  logic [BW-1:0] w_pending_nxt;

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

`ifdef BANK_BUF_LATEST_EN
  function automatic logic [BW-1:0] bank_dec(input logic [BW-1:0] b);
    return (b == '0) ? LAST_BANK : b - 1'b1;
  endfunction
`endif

  assign w_wen    = irst_n & iwr & ~r_full;
  // A swap in the same cycle frees a slot, so the commit can always land.
  assign w_accept = icommit & ((r_pending < PEND_LIMIT) | iswap);
  assign w_take   = iswap & ((r_pending != '0) | w_accept);

  always_comb begin
    w_wr_bank_nxt = w_accept ? bank_inc(r_wr_bank) : r_wr_bank;
    w_rd_bank_nxt = r_rd_bank;
    w_pending_nxt = r_pending;
`ifdef BANK_BUF_LATEST_EN
    // Newest committed bank is the one closing now, otherwise the one just behind the writer.
    if (w_take) begin
      w_rd_bank_nxt = w_accept ? r_wr_bank : bank_dec(r_wr_bank);
      w_pending_nxt = '0;
    end else if (w_accept) begin
      w_pending_nxt = r_pending + 1'b1;
    end
`else
    if (w_take) w_rd_bank_nxt = bank_inc(r_rd_bank);
    if (w_accept && !w_take)      w_pending_nxt = r_pending + 1'b1;
    else if (w_take && !w_accept) w_pending_nxt = r_pending - 1'b1;
`endif
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_rd_bank <= BW'(RST_RD_BANK);
      r_wr_bank <= BW'(RST_WR_BANK);
      r_pending <= '0;
      r_waddr   <= '0;
      r_full    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_rd_bank <= w_rd_bank_nxt;
      r_wr_bank <= w_wr_bank_nxt;
      r_pending <= w_pending_nxt;
      r_drop    <= icommit & ~w_accept;
      if (icommit) begin
        r_waddr <= '0;
        r_full  <= 1'b0;
      end else if (w_wen) begin
        if (r_waddr == LAST_WORD) r_full <= 1'b1;
        else                      r_waddr <= r_waddr + 1'b1;
      end
    end
  end

  bank_buf_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .NBANKS    (NBANKS)
  ) u_ram (
    .i_clk  (iclk),
    .i_rst_n(irst_n),
    .i_we   (w_wen),
    .i_waddr({r_wr_bank, r_waddr}),
    .i_wdata(idata),
    .i_raddr({r_rd_bank, iraddr}),
    .o_rdata(odata)
  );

  assign owr_bank = r_wr_bank;
  assign ord_bank = r_rd_bank;
  assign opending = r_pending;
  assign odrop    = r_drop;
  assign ofull    = r_full;

endmodule

// File: doc/bank_buf.md
BANK_BUF -- requirements
Module: bank_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, words per bank, at least 2.
REQ-003 SHALL have parameter NBANKS, default 3, number of banks, at least 2.
REQ-004 SHALL have port iclk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port irst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port idata  in  DATA_WIDTH  write data.
REQ-007 SHALL have port iwr  in  1  write strobe; stores idata at the internal write address of the write bank.
REQ-008 SHALL have port icommit  in  1  closes the write bank and hands it to the reader queue.
REQ-009 SHALL have port iswap  in  1  reader releases its bank and takes the next committed bank.
REQ-010 SHALL have port iraddr  in  clog2(DEPTH)  read word address within the read bank.
REQ-011 SHALL have port odata  out  DATA_WIDTH  registered read data.
REQ-012 SHALL have port owr_bank  out  clog2(NBANKS)  current write bank index.
REQ-013 SHALL have port ord_bank  out  clog2(NBANKS)  current read bank index.
REQ-014 SHALL have port opending  out  clog2(NBANKS)  count of committed, unread banks.
REQ-015 SHALL have port odrop  out  1  one-cycle pulse when a commit is refused.
REQ-016 SHALL have port ofull  out  1  write bank is at word DEPTH-1 and already written.

Function
REQ-017 Write address SHALL start at 0 and increment on each iwr; at DEPTH-1 a write SHALL set ofull, and further iwr SHALL be ignored until commit.
REQ-018 odata SHALL equal word iraddr of the read bank, one cycle after iraddr is presented.
REQ-019 A commit SHALL be accepted when opending < NBANKS-2, or when iswap is asserted in the same cycle.
REQ-020 On an accepted commit, owr_bank SHALL advance modulo NBANKS, opending SHALL increment, write address SHALL return to 0, and ofull SHALL clear.
REQ-021 On a refused commit, odrop SHALL pulse, owr_bank SHALL hold, and write address SHALL return to 0. The bank's content is discarded.
REQ-022 iswap with opending = 0 and no simultaneous commit SHALL have no effect.
REQ-023 In FIFO mode, iswap with a bank available SHALL advance ord_bank modulo NBANKS and decrement opending.
REQ-024 Simultaneous commit and swap with opending = 0 SHALL bypass: ord_bank takes the just-committed bank, and opending stays 0.
REQ-025 iwr together with icommit SHALL store the word in the closing bank before the commit takes effect.
REQ-026 The reader SHALL never see its bank written; owr_bank SHALL never equal ord_bank.
REQ-027 Reads across a swap edge SHALL return data from the bank selected at the iraddr sample edge.

Reset
REQ-028 While irst_n is low at a clock edge, the block SHALL force the following on that edge: ord_bank = 0, owr_bank = 1, opending = 0, write address = 0, odata = 0, odrop = 0, ofull = 0.
REQ-029 Reset mid-frame SHALL discard all pending banks; RAM contents are not cleared.

Configuration
REQ-030 With macro BANK_BUF_LATEST_EN defined, iswap SHALL jump ord_bank to the newest committed bank and set opending to 0. This includes the bank committed in the same cycle. Older pending banks are dropped silently.
REQ-031 Without BANK_BUF_LATEST_EN, iswap SHALL follow the FIFO order of REQ-023.

Structure
REQ-032 Package bank_buf_pkg SHALL hold a clog2 function and bank-index/address width derivations.
REQ-033 Bank storage SHALL be sub-module bank_buf_ram: simple dual-port, one write port, one registered read port, NBANKS*DEPTH words, addressed {bank, word}.

Verification
REQ-034 Reset, then read address 0 -> odata = 0, ord_bank = 0, owr_bank = 1, opending = 0.
REQ-035 Write 4 words 0x11..0x14, commit, swap, read addresses 0..3 -> odata = 0x11..0x14 one cycle after each address; ord_bank = 1.
REQ-036 NBANKS = 3, commit twice without swap -> second commit gives odrop = 1, owr_bank = 2, opending = 1.
REQ-037 NBANKS = 2, opending = 0, commit and swap in the same cycle -> ord_bank = 1, owr_bank = 0, opending = 0, odrop = 0.
REQ-038 DEPTH = 4, 6 writes of 0xA0..0xA5 -> ofull = 1 after the fourth; the bank reads back 0xA0..0xA3.
REQ-039 With BANK_BUF_LATEST_EN, NBANKS = 4, two commits then swap -> ord_bank = 2, opending = 0; the same sequence without the macro -> ord_bank = 1, opending = 1.
